// File: rtl/hazard_sched_if.sv
// Pipeline-control bundle between the hazard scheduler and the pipeline datapath.
interface hazard_sched_if;
  logic        idex_memrd;
  logic [4:0]  idex_dest;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_uses_rt;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_bubble;
  logic        exmem_write;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output idex_memrd, idex_dest, ifid_rs, ifid_rt, ifid_uses_rt,
           branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  idex_memrd, idex_dest, ifid_rs, ifid_rt, ifid_uses_rt,
           branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stalls, branch flushes and memory-wait freezes
// with a deferred flush for branches resolved while the pipeline is frozen.
module hazard_sched #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  hazard_sched_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH_PEND} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_branch_pend, w_branch_pend_nxt;
  logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        r_mem_err, w_mem_err_nxt;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_stall_inc, w_flush_inc;
  logic        w_hazard, w_mem_stall, w_timeout, w_branch_any;
  logic        w_pc_write, w_ifid_write, w_ifid_flush;
  logic        w_idex_write, w_idex_bubble, w_exmem_write;

  assign w_hazard = bus.idex_memrd && (bus.idex_dest != 5'd0) &&
                    ((bus.idex_dest == bus.ifid_rs) ||
                     (bus.ifid_uses_rt && (bus.idex_dest == bus.ifid_rt)));
  assign w_mem_stall  = bus.mem_req && !bus.mem_ready;
  assign w_timeout    = (r_wait_cnt == 8'(MEM_TIMEOUT));
  assign w_branch_any = r_branch_pend || bus.branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_branch_pend <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_err     <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_branch_pend <= w_branch_pend_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_err     <= w_mem_err_nxt;
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_inc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_branch_pend_nxt = r_branch_pend;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_err_nxt     = r_mem_err;
    w_stall_inc       = 1'b0;
    w_flush_inc       = 1'b0;
    w_pc_write        = 1'b1;
    w_ifid_write      = 1'b1;
    w_ifid_flush      = 1'b0;
    w_idex_write      = 1'b1;
    w_idex_bubble     = 1'b0;
    w_exmem_write     = 1'b1;

    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = '0;
          w_state_nxt       = MEM_WAIT;
          w_wait_cnt_nxt    = 8'd1;
          w_branch_pend_nxt = bus.branch_taken;
          w_stall_inc       = 1'b1;
        end else if (bus.branch_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_flush_inc   = 1'b1;
        end else if (w_hazard) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_stall_inc   = 1'b1;
        end
      end

      MEM_WAIT: begin
        // A branch seen on the exit cycle is still deferred to FLUSH_PEND.
        w_branch_pend_nxt = w_branch_any;
        if (w_mem_stall && !w_timeout) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = '0;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          w_stall_inc    = 1'b1;
        end else begin
          if (w_mem_stall)
            w_mem_err_nxt = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = w_branch_any ? FLUSH_PEND : RUN;
        end
      end

      FLUSH_PEND: begin
        if (w_mem_stall) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = '0;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
          w_stall_inc    = 1'b1;
        end else begin
          w_ifid_flush      = 1'b1;
          w_idex_bubble     = 1'b1;
          w_flush_inc       = 1'b1;
          w_branch_pend_nxt = 1'b0;
          w_state_nxt       = RUN;
        end
      end

      default: w_state_nxt = RUN;
    endcase
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_write  = w_idex_write;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.exmem_write = w_exmem_write;
  assign bus.mem_err     = r_mem_err;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: stalls, flushes, memory freeze, timeout and reset.
module tb_hazard_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_sched_if bus ();

  hazard_sched #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Enable vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] EN_RUN = 6'b110101;
  localparam logic [5:0] EN_FRZ = 6'b000000;
  localparam logic [5:0] EN_HAZ = 6'b000111;
  localparam logic [5:0] EN_FLS = 6'b111111;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_en(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
           bus.idex_write, bus.idex_bubble, bus.exmem_write};
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic drive(input logic memrd, input logic [4:0] dest, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses_rt, input logic br,
                       input logic req, input logic rdy);
    bus.idex_memrd   = memrd;
    bus.idex_dest    = dest;
    bus.ifid_rs      = rs;
    bus.ifid_rt      = rt;
    bus.ifid_uses_rt = uses_rt;
    bus.branch_taken = br;
    bus.mem_req      = req;
    bus.mem_ready    = rdy;
  endtask

  // Inputs already applied; check combinational enables, then advance one cycle.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #1;
    check_en(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_cnts(input string tag, input int stalls, input int flushes);
    check({tag, "_stall"}, 32'(bus.stall_cnt), 32'(stalls));
    check({tag, "_flush"}, 32'(bus.flush_cnt), 32'(flushes));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check_en("reset_en", EN_RUN);
    check("reset_err", 32'(bus.mem_err), 32'd0);
    check_cnts("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cyc("idle", EN_RUN);

    // Load-use hazards
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("loaduse_rs", EN_HAZ);
    check_cnts("loaduse_rs", 1, 0);
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("loaduse_rt", EN_HAZ);
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rt_unused", EN_RUN);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("dest_zero", EN_RUN);
    check_cnts("hazards", 2, 0);

    // Branch in RUN, and branch beating a hazard
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("branch", EN_FLS);
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("branch_hazard", EN_FLS);
    check_cnts("branches", 2, 2);

    // Three frozen cycles then memory completes
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("memwait", EN_FRZ);
    bus.mem_ready = 1'b1;
    cyc("mem_done", EN_RUN);
    idle();
    cyc("after_mem", EN_RUN);
    check_cnts("memwait", 5, 2);

    // Branch during freeze becomes one flush after mem_ready
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("bw_enter", EN_FRZ);
    bus.branch_taken = 1'b1;
    cyc("bw_branch", EN_FRZ);
    bus.branch_taken = 1'b0;
    cyc("bw_wait", EN_FRZ);
    bus.mem_ready = 1'b1;
    cyc("bw_ready", EN_RUN);
    idle();
    cyc("bw_flush", EN_FLS);
    cyc("bw_after", EN_RUN);
    check_cnts("bw", 8, 3);

    // Simultaneous stall, branch and hazard: freeze only
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("all3", EN_FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("all3_wait", EN_FRZ);
    bus.mem_ready = 1'b1;
    cyc("all3_ready", EN_RUN);
    idle();
    cyc("all3_flush", EN_FLS);
    check_cnts("all3", 10, 4);

    // New stall in FLUSH_PEND freezes and keeps the pending branch
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("fp_enter", EN_FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("fp_ready1", EN_RUN);
    bus.mem_ready = 1'b0;
    cyc("fp_restall", EN_FRZ);
    bus.mem_ready = 1'b1;
    cyc("fp_ready2", EN_RUN);
    idle();
    cyc("fp_flush", EN_FLS);
    cyc("fp_after", EN_RUN);
    check_cnts("fp", 12, 5);

    // Timeout with MEM_TIMEOUT=4
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("to_wait", EN_FRZ);
    check("to_err_before", 32'(bus.mem_err), 32'd0);
    cyc("to_expire", EN_RUN);
    check("to_err_set", 32'(bus.mem_err), 32'd1);
    idle();
    cyc("to_after", EN_RUN);
    cyc("to_after2", EN_RUN);
    check("to_err_sticky", 32'(bus.mem_err), 32'd1);
    check_cnts("to", 16, 5);

    // Asynchronous reset mid MEM_WAIT with a pending branch
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("rst_enter", EN_FRZ);
    idle();
    rst = 1'b1;
    #1;
    check_en("rst_async_en", EN_RUN);
    check("rst_async_err", 32'(bus.mem_err), 32'd0);
    check_cnts("rst_async", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_noflush", EN_RUN);
    check_cnts("rst_after", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
